// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings, FSM state encoding and word-index width for the load/store unit
package lsu_pkg;

   // Word index into the attached data memory (32 words)
   localparam int IDX_W = 5;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size carried in funct3[1:0]
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   function automatic logic is_bad_funct3(input logic [2:0] f3);
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load lane select/extension and store lane merge
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word_in,
   input  logic [15:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  lane8;
   logic [15:0] lane16;
   logic [4:0]  sh;

   // Byte offset is already aligned to the access size, so it addresses the lane directly
   always_comb begin
      sh         = {byte_off, 3'b000};
      lane8      = word_in[sh +: 8];
      lane16     = word_in[{byte_off[1], 4'b0000} +: 16];
      load_data  = '0;
      merge_data = word_in;
      case (funct3[1:0])
         SZ_B: begin
            load_data  = {{24{~funct3[2] & lane8[7]}}, lane8};
            merge_data = (word_in & ~(32'h0000_00FF << sh)) | ({24'b0, store_data[7:0]} << sh);
         end
         SZ_H: begin
            load_data  = {{16{~funct3[2] & lane16[15]}}, lane16};
            merge_data = (word_in & ~(32'h0000_FFFF << sh)) | ({16'b0, store_data} << sh);
         end
         SZ_W: begin
            load_data  = word_in;
            merge_data = word_in;
         end
         default: begin
            load_data  = '0;
            merge_data = word_in;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store FSM; define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rdata,
   output logic             resp_err,
   output logic [IDX_W-1:0] read_addr,
   output logic [IDX_W-1:0] write_addr,
   output logic [31:0]      write_data,
   output logic             sw,
   input  logic [31:0]      read_data
);

   logic [1:0]       state;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       f3_q;
   logic             we_q;
   logic [1:0]       off_q;
   logic [15:0]      wdata_q;

   logic [1:0]       req_size;
   logic [IDX_W-1:0] req_idx;
   logic [1:0]       req_off;
   logic             req_fault;
   logic [31:0]      load_data;
   logic [31:0]      merge_data;

   assign req_size = req_funct3[1:0];
   assign req_idx  = req_addr[6:2];

`ifdef LSU_MISALIGN_TRAP_EN
   logic req_misalign;
   assign req_misalign = (req_size == SZ_H && req_addr[0]) ||
                         (req_size == SZ_W && req_addr[1:0] != 2'b00);
   assign req_fault = is_bad_funct3(req_funct3) ||
                      (req_addr >= 32'(MEM_WORDS) * 32'd4) || req_misalign;
`else
   assign req_fault = is_bad_funct3(req_funct3) ||
                      (req_addr >= 32'(MEM_WORDS) * 32'd4);
`endif

   // Clear low address bits below the access size; a trapping build has already faulted these
   always_comb begin
      case (req_size)
         SZ_H:    req_off = {req_addr[1], 1'b0};
         SZ_W:    req_off = 2'b00;
         default: req_off = req_addr[1:0];
      endcase
   end

   lsu_align u_align (
      .funct3     (f3_q),
      .byte_off   (off_q),
      .word_in    (read_data),
      .store_data (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign sw         = (state == ST_WR);
   assign write_addr = idx_q;
   // The memory read is one cycle deep, so the accept cycle already presents the incoming index
   assign read_addr  = (state == ST_IDLE && reset && req_valid && !req_fault) ? req_idx : idx_q;

   // Request capture, IDLE/RD/WR/RESP sequencing and response registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         idx_q      <= '0;
         f3_q       <= '0;
         we_q       <= 1'b0;
         off_q      <= '0;
         wdata_q    <= '0;
         write_data <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  idx_q   <= req_idx;
                  f3_q    <= req_funct3;
                  we_q    <= req_we;
                  off_q   <= req_off;
                  wdata_q <= req_wdata[15:0];
                  if (req_fault) begin
                     state      <= ST_RESP;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else if (req_we && req_size == SZ_W) begin
                     state      <= ST_WR;
                     write_data <= req_wdata;
                  end else begin
                     state <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (we_q) begin
                  write_data <= merge_data;
                  state      <= ST_WR;
               end else begin
                  resp_rdata <= load_data;
                  resp_err   <= 1'b0;
                  state      <= ST_RESP;
               end
            end
            ST_WR: begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
               state      <= ST_RESP;
            end
            default: begin
               if (resp_ready) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with behavioural memory and reference model
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [4:0]  read_addr;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        sw;
   logic [31:0] read_data;

   logic [31:0] mem     [0:31];
   logic [31:0] ref_mem [0:31];
   logic        pl_en;
   logic [4:0]  pl_addr;
   logic [31:0] pl_data;

   int          checks = 0;
   int          errors = 0;
   int          got_lat;
   int          got_sw;
   logic [31:0] got_rdata;
   logic [31:0] got_wa;
   logic [31:0] got_wd;

   load_store_unit #(.MEM_WORDS(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .read_addr  (read_addr),
      .write_addr (write_addr),
      .write_data (write_data),
      .sw         (sw),
      .read_data  (read_data)
   );

   always #5 clk = ~clk;

   // Synchronous-read data memory with a bench-only preload port
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (sw) mem[write_addr] <= write_data;
      read_data <= mem[read_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic model_fault(input logic [2:0] f3, input logic [31:0] a);
      logic f;
      f = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) || (a >= 32'd128);
`ifdef LSU_MISALIGN_TRAP_EN
      if (f3[1:0] == 2'd1 && a[0]) f = 1'b1;
      if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) f = 1'b1;
`endif
      return f;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v;
      int          sh;
      case (f3[1:0])
         2'd0: begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
         end
         2'd1: begin
            sh = 16 * int'(a[1]);
            v  = (w >> sh) & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [31:0] w);
      logic [31:0] mask;
      int          sh;
      case (f3[1:0])
         2'd0: begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
         end
         2'd1: begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
         end
         default: return wd;
      endcase
   endfunction

   // One complete transaction: predict, drive, measure latency, check response, hold, release
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
      logic        fault;
      logic [4:0]  idx;
      logic [31:0] e_rd;
      logic [31:0] e_word;
      int          e_lat;
      int          e_sw;
      fault  = model_fault(f3, a);
      idx    = a[6:2];
      e_rd   = 32'd0;
      e_word = ref_mem[idx];
      e_sw   = 0;
      if (fault) e_lat = 1;
      else if (!we) begin
         e_lat = 2;
         e_rd  = model_load(f3, a, ref_mem[idx]);
      end else begin
         e_sw   = 1;
         e_lat  = (f3[1:0] == 2'd2) ? 2 : 3;
         e_word = model_store(f3, a, wd, ref_mem[idx]);
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      got_lat = 1;
      got_sw  = 0;
      got_wa  = 32'hFFFF_FFFF;
      got_wd  = 32'hFFFF_FFFF;
      while (resp_valid !== 1'b1 && got_lat < 8) begin
         if (sw === 1'b1) begin
            got_sw++;
            got_wa = 32'(write_addr);
            got_wd = write_data;
         end
         @(negedge clk);
         got_lat++;
      end
      got_rdata = resp_rdata;
      chk("resp_valid_seen", 32'(resp_valid), 32'd1);
      chk("latency", 32'(got_lat), 32'(e_lat));
      chk("sw_pulses", 32'(got_sw), 32'(e_sw));
      chk("resp_err", 32'(resp_err), 32'(fault));
      chk("resp_rdata", resp_rdata, e_rd);
      if (e_sw == 1) begin
         chk("write_addr", got_wa, 32'(idx));
         chk("write_data", got_wd, e_word);
         ref_mem[idx] = e_word;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, e_rd);
         chk("hold_err", 32'(resp_err), 32'(fault));
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_sw", 32'(sw), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("release_valid", 32'(resp_valid), 32'd0);
      chk("release_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a;
      int          r_sel;
      logic [2:0]  st_f3 [0:4];
      st_f3[0] = 3'd0; st_f3[1] = 3'd1; st_f3[2] = 3'd2; st_f3[3] = 3'd3; st_f3[4] = 3'd7;

      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;
      pl_en      = 1'b0;
      pl_addr    = 5'd0;
      pl_data    = 32'd0;

      // Preload memory while reset is held
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = $urandom;
         if (i == 1) ref_mem[i] = 32'hCAFE_F00D;
         if (i == 3) ref_mem[i] = 32'h1122_3344;
         pl_addr = 5'(i);
         pl_data = ref_mem[i];
         pl_en   = 1'b1;
         @(negedge clk);
      end
      pl_en = 1'b0;
      @(negedge clk);

      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_sw", 32'(sw), 32'd0);
      chk("rst_read_addr", 32'(read_addr), 32'd0);
      chk("rst_write_addr", 32'(write_addr), 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Directed scenarios
      do_req(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, 0);
      chk("sw08_write_addr", got_wa, 32'd2);
      chk("sw08_write_data", got_wd, 32'hDEAD_BEEF);
      chk("sw08_latency", 32'(got_lat), 32'd2);
      do_req(1'b0, 3'b000, 32'h0B, 32'd0, 0);
      chk("lb_0b", got_rdata, 32'hFFFF_FFDE);
      do_req(1'b0, 3'b100, 32'h0B, 32'd0, 0);
      chk("lbu_0b", got_rdata, 32'h0000_00DE);
      do_req(1'b0, 3'b001, 32'h08, 32'd0, 0);
      chk("lh_08", got_rdata, 32'hFFFF_BEEF);
      do_req(1'b1, 3'b000, 32'h0D, 32'h0000_00AA, 0);
      chk("sb_0d_latency", 32'(got_lat), 32'd3);
      chk("sb_0d_mem3", mem[3], 32'h1122_AA44);
      do_req(1'b0, 3'b010, 32'h80, 32'd0, 0);
      chk("lw_80_latency", 32'(got_lat), 32'd1);
      chk("lw_80_rdata", got_rdata, 32'd0);
      chk("lw_80_sw", 32'(got_sw), 32'd0);
      do_req(1'b0, 3'b010, 32'h06, 32'd0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lw_06_fault_rdata", got_rdata, 32'd0);
`else
      chk("lw_06_aligned", got_rdata, 32'hCAFE_F00D);
`endif
      do_req(1'b0, 3'b101, 32'h0E, 32'd0, 5);

      // Reset pulse while an SB sits in RD must abort without writing
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h14;
      req_wdata  = 32'h0000_0055;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_rd_busy", 32'(req_ready), 32'd0);
      chk("abort_rd_sw", 32'(sw), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(req_ready), 32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_sw", 32'(sw), 32'd0);
      chk("abort_write_data", write_data, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_mem5", mem[5], ref_mem[5]);

      // Randomized traffic against the reference model
      for (int n = 0; n < 80; n++) begin
         r_we  = 1'($urandom_range(0, 1));
         r_f3  = r_we ? st_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
         r_sel = $urandom_range(0, 9);
         r_a   = (r_sel == 0) ? ($urandom | 32'h80) : 32'($urandom_range(0, 127));
         do_req(r_we, r_f3, r_a, $urandom, $urandom_range(0, 3));
      end

      @(negedge clk);
      for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, meaning number of 32-bit words in the attached data memory (address width 5).
REQ-002 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have CPU request ports: req_valid in 1; req_ready out 1; req_we in 1 (1 = store); req_funct3 in 3 (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW); req_addr in 32 byte address; req_wdata in 32 store data.
REQ-005 SHALL have CPU response ports: resp_valid out 1; resp_ready in 1; resp_rdata out 32 extended load data; resp_err out 1 access fault.
REQ-006 SHALL have memory-initiator ports: read_addr out 5; write_addr out 5; write_data out 32; sw out 1 store enable; read_data in 32, registered by memory, valid the cycle after read_addr is presented.

Function
REQ-007 SHALL accept a request when req_valid & req_ready; req_ready = 1 only in IDLE.
REQ-008 SHALL latch addr, funct3, we, wdata on accept; later changes to req_* SHALL be ignored.
REQ-009 SHALL use FSM states IDLE, RD, WR, RESP.
REQ-010 Transitions: IDLE->RD (load or SB/SH); IDLE->WR (SW); IDLE->RESP (fault); RD->RESP (load); RD->WR (SB/SH); WR->RESP; RESP->IDLE when resp_ready.
REQ-011 Word index = addr[6:2]; read_addr and write_addr SHALL both carry it in every state.
REQ-012 sw SHALL be 1 only in WR, for exactly one cycle per store.
REQ-013 Latency from accept to resp_valid: load 2 cycles, SW 2, SB/SH 3 (read-modify-write), fault 1.
REQ-014 Load data SHALL be captured from read_data at RD->RESP transition and held stable in RESP.
REQ-015 LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; lane selected by addr[1:0] (byte) or addr[1] (half).
REQ-016 SB/SH SHALL merge the new byte/half into the word read in RD; other lanes SHALL be unchanged.
REQ-017 resp_rdata SHALL be 0 for stores and faults.
REQ-018 Out-of-range address (addr[31:7] != 0) SHALL set resp_err = 1 and issue no memory access.
REQ-019 resp_valid, resp_rdata, resp_err SHALL hold until resp_ready; resp_valid & resp_ready in the same cycle returns to IDLE next cycle.
REQ-020 Undefined funct3 (011, 110, 111) SHALL be treated as a fault.

Reset
REQ-021 On reset = 0 at a clock edge: state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, sw = 0, read_addr = write_addr = 0, write_data = 0.
REQ-022 Reset mid-operation SHALL abort; an aborted SB/SH in RD SHALL NOT write memory.

Configuration
REQ-023 With LSU_MISALIGN_TRAP_EN defined: half access with addr[0] != 0 or word access with addr[1:0] != 0 SHALL fault (REQ-018 behaviour).
REQ-024 Without LSU_MISALIGN_TRAP_EN: misaligned low bits SHALL be forced to alignment (cleared), no fault.

Structure
REQ-025 Shared package lsu_pkg SHALL hold funct3 encodings, FSM state encoding, and the word-index width.
REQ-026 Combinational sub-module lsu_align SHALL implement load lane-select/extension and store lane-merge; the FSM lives in load_store_unit.

Verification
REQ-027 SW addr 0x08 data 0xDEADBEEF -> sw = 1 one cycle, write_addr = 2, write_data = 0xDEADBEEF; resp_valid 2 cycles after accept, resp_err = 0.
REQ-028 Mem[2] = 0xDEADBEEF; LB addr 0x0B -> resp_rdata 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x08 -> 0xFFFFBEEF.
REQ-029 Mem[3] = 0x11223344; SB addr 0x0D data 0xAA -> memory word 3 = 0x1122AA44, resp after 3 cycles.
REQ-030 LW addr 0x80 -> resp_err = 1 after 1 cycle, sw never asserted, resp_rdata = 0.
REQ-031 LW addr 0x06: with LSU_MISALIGN_TRAP_EN -> resp_err = 1; without -> returns Mem[1], resp_err = 0.
REQ-032 Hold resp_ready = 0 for 5 cycles -> response stable, req_ready = 0; pulse reset = 0 during RD of SB -> no write, IDLE next cycle.
